router_output_port_ctrl: RTL
============================

// Module: router_output_port_ctrl
//
// PURPOSE
// Wormhole output-port controller for one NoC router output. Allocates the port among NIN
// input ports using round-robin. Locks the grant from a head flit through its tail flit.
// Gates forwarding on downstream credits. Drives one registered flit per cycle toward the
// neighbour router or the local tile. Replaces the ad-hoc head/tail and credit glue
// currently around each per-output arbiter.
//
// PARAMETERS
// NIN      5   number of input ports competing for this output
// FLIT_W   34  flit width; bit FLIT_W-1 = head, bit FLIT_W-2 = tail, rest payload
// CREDITS  4   downstream input-buffer depth (initial/max credit count)
//
// PORTS
// clk           in   1             clock
// rst           in   1             reset rst, synchronous, active-high
// in_valid      in   NIN           input port i has a flit at its queue head routed to this output
// in_flit       in   NIN*FLIT_W    flit of input i (slice i)
// in_ready      out  NIN           one-hot/zero pop strobe; in_flit[i] consumed this cycle
// out_valid     out  1             registered flit valid toward downstream
// out_flit      out  FLIT_W        registered flit
// credit_return in   1             downstream freed one buffer slot this cycle
// owner         out  NIN           one-hot current packet owner (zero when IDLE)
// credits       out  $clog2(CREDITS+1)  current credit count
//
// BEHAVIOUR
// - Reset: state=IDLE, owner=0, priority pointer=0 (input 0 highest), credits=CREDITS,
//   out_valid=0, out_flit=0, in_ready=0.
// - in_ready is combinational: zero-cycle request->pop, as for the existing arbiter.
// - A flit is forwarded (fwd) in a cycle where in_ready[i]=1.
//   At the next clock edge: out_flit<=in_flit[i], out_valid<=1.
//   Fixed latency: 1 cycle. out_valid=0 on every cycle after no fwd.
// - Forwarding requires credits>0. credits decrements on fwd, increments on credit_return.
//   When fwd and credit_return occur together, credits is unchanged.
//   credit_return at credits==CREDITS: saturate and fire an assertion.
// - IDLE state:
//   - Eligible inputs: in_valid[i] & in_flit[i][head].
//   - If credits>0, pick the first eligible input at or after the pointer (round-robin, wraps
//     NIN-1->0), assert in_ready for it, and set pointer<=winner+1 mod NIN, so the winner
//     becomes lowest priority.
//   - If the picked flit has head and tail both set (single-flit packet), stay IDLE.
//     Otherwise go to LOCKED with owner<=winner.
//   - A valid non-head flit in IDLE is never granted; an assertion flags it.
// - LOCKED state:
//   - Only the owner is served. in_ready[owner] = in_valid[owner] & credits>0.
//   - Other requests wait, even with credits available; there is no pre-emption.
//   - On fwd of a tail: go to IDLE, owner<=0. The next head may be granted the cycle after.
//   - A head flit from the owner while LOCKED is a protocol error; assert on it.
// - Zero credits: no fwd in either state. State, owner and pointer all hold.
// - Reset mid-packet: immediate return to reset values. Any partially sent packet is
//   abandoned; the upstream and downstream ports are reset by the same rst.
// - Assertions: $onehot0(in_ready), $onehot0(owner), credits<=CREDITS,
//   in_ready[i] -> in_valid[i].
//
// STRUCTURE
// - Package router_pkg:
//   - localparams HEAD_BIT and TAIL_BIT (offsets from the MSB).
//   - typedef enum logic {IDLE, LOCKED} port_state_t.
//   - function credit_w(CREDITS).
// - Sub-module router_rr_pick #(N):
//   - Combinational one-hot pick from req and ptr, plus a registered ptr with an update
//     enable.
//   - The pointer updates only on head fwd.
//   - Shared with future VC allocators.
// - Top level: FSM, credit counter, output register, flit mux (AND-OR on the one-hot grant).
//
// TESTING
// 1) Reset, then in_valid=5'b00101 heads (multi-flit) with 4 credits -> input 0 granted
//    first. Pointer moves to 1. Input 2 is granted only after input 0's tail.
// 2) All 5 inputs send continuous single-flit packets, credit_return every cycle -> grant
//    order 0,1,2,3,4,0...; out_valid high every cycle from cycle 2.
// 3) Owner sends a 6-flit packet, CREDITS=4, no credit_return -> 4 flits forwarded, then
//    stall with credits=0. Single credit_return -> exactly 1 more flit, 1 cycle later on out.
// 4) fwd and credit_return in the same cycle at credits=1 -> credits stays 1. Stream
//    continues without a bubble.
// 5) Input 3 holds a non-head flit while IDLE and input 1 holds a head -> only input 1
//    granted. Assertion fires for input 3.
// 6) rst asserted mid-packet after flit 2 of 5 -> next cycle: state IDLE, owner=0,
//    credits=4, out_valid=0, pointer=0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the router output-port controller and its arbiter.
package router_pkg;

  // Offsets of the control bits counted down from the flit MSB.
  localparam int unsigned HEAD_BIT = 0;
  localparam int unsigned TAIL_BIT = 1;

  typedef enum logic {IDLE, LOCKED} port_state_t;

  function automatic int unsigned credit_w(int unsigned credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/router_rr_pick.sv
// Round-robin one-hot picker: combinational grant from req, registered priority pointer.
module router_rr_pick #(
  parameter int unsigned N = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N-1:0]                    req,
  input  logic                            upd,
  output logic [N-1:0]                    grant,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d, win_idx;
  logic          found;
  int unsigned   idx;

  // Scan from the pointer upward with wrap; first requester wins.
  always_comb begin
    grant   = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win_idx    = PW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (upd && found) begin
      ptr_d = (win_idx == PW'(N - 1)) ? '0 : win_idx + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/router_output_port_ctrl.sv
// Wormhole output-port controller: round-robin head allocation, packet lock, credit gating,
// and a registered output flit.
module router_output_port_ctrl
  import router_pkg::*;
#(
  parameter int unsigned NIN     = 5,
  parameter int unsigned FLIT_W  = 34,
  parameter int unsigned CREDITS = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NIN-1:0]                    in_valid,
  input  logic [NIN*FLIT_W-1:0]             in_flit,
  output logic [NIN-1:0]                    in_ready,
  output logic                              out_valid,
  output logic [FLIT_W-1:0]                 out_flit,
  input  logic                              credit_return,
  output logic [NIN-1:0]                    owner,
  output logic [credit_w(CREDITS)-1:0]      credits
);

  localparam int unsigned CW   = credit_w(CREDITS);
  localparam int unsigned HPOS = FLIT_W - 1 - HEAD_BIT;
  localparam int unsigned TPOS = FLIT_W - 1 - TAIL_BIT;
  localparam int unsigned PW   = (NIN > 1) ? $clog2(NIN) : 1;

  port_state_t       state_q, state_d;
  logic [NIN-1:0]    owner_q, owner_d;
  logic [CW-1:0]     credits_q, credits_d;
  logic              out_valid_q;
  logic [FLIT_W-1:0] out_flit_q, sel_flit;
  logic [NIN-1:0]    heads, elig, rr_grant;
  logic [PW-1:0]     rr_ptr;
  logic              has_credit, credits_full, fwd, sel_head, sel_tail, rr_upd;
  logic              nonhead_idle_err, owner_head_err;

  always_comb begin
    heads = '0;
    for (int unsigned i = 0; i < NIN; i++) begin
      heads[i] = in_flit[i*FLIT_W + HPOS];
    end
  end

  assign elig         = in_valid & heads;
  assign has_credit   = (credits_q != '0);
  assign credits_full = (credits_q == CW'(CREDITS));

  router_rr_pick #(
    .N (NIN)
  ) u_rr (
    .clk   (clk),
    .rst   (rst),
    .req   (elig),
    .upd   (rr_upd),
    .grant (rr_grant),
    .ptr   (rr_ptr)
  );

  always_comb begin
    in_ready = '0;
    unique case (state_q)
      IDLE:    in_ready = has_credit ? rr_grant : '0;
      LOCKED:  in_ready = owner_q & in_valid & {NIN{has_credit}};
      default: in_ready = '0;
    endcase
  end

  assign fwd    = |in_ready;
  assign rr_upd = (state_q == IDLE) && fwd;

  // AND-OR mux on the one-hot grant.
  always_comb begin
    sel_flit = '0;
    for (int unsigned i = 0; i < NIN; i++) begin
      sel_flit = sel_flit | (in_flit[i*FLIT_W +: FLIT_W] & {FLIT_W{in_ready[i]}});
    end
  end

  assign sel_head = sel_flit[HPOS];
  assign sel_tail = sel_flit[TPOS];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    unique case (state_q)
      IDLE: begin
        if (fwd && !(sel_head && sel_tail)) begin
          state_d = LOCKED;
          owner_d = in_ready;
        end
      end
      LOCKED: begin
        if (fwd && sel_tail) begin
          state_d = IDLE;
          owner_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = '0;
      end
    endcase
  end

  always_comb begin
    credits_d = credits_q;
    if (fwd && !credit_return) begin
      credits_d = credits_q - CW'(1);
    end else if (!fwd && credit_return && !credits_full) begin
      credits_d = credits_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      credits_q   <= CW'(CREDITS);
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      credits_q   <= credits_d;
      out_valid_q <= fwd;
      if (fwd) begin
        out_flit_q <= sel_flit;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_flit  = out_flit_q;
  assign owner     = owner_q;
  assign credits   = credits_q;

  assign nonhead_idle_err = (state_q == IDLE) && |(in_valid & ~heads);
  assign owner_head_err   = (state_q == LOCKED) && |(owner_q & in_valid & heads);

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));
  a_owner_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(owner_q));
  a_credit_max:   assert property (@(posedge clk) disable iff (rst) credits_q <= CW'(CREDITS));
  a_ready_valid:  assert property (@(posedge clk) disable iff (rst) (in_ready & ~in_valid) == '0);

  // Upstream protocol violations are reported but not treated as design faults.
  a_nonhead_idle: assert property (@(posedge clk) disable iff (rst) !nonhead_idle_err)
    else $warning("non-head flit presented while port idle");
  a_owner_head:   assert property (@(posedge clk) disable iff (rst) !owner_head_err)
    else $warning("head flit from owner while locked");
  a_credit_sat:   assert property (@(posedge clk) disable iff (rst)
                                   !(credit_return && credits_full && !fwd))
    else $warning("credit return with counter already full");

endmodule
